// File: rtl/prog_timer.sv
// -----------------------------------------------------------------------------
// prog_timer
//   Programmable timer. It counts enabled, prescaled ticks from 1 up to a
//   programmed rollover value. In continuous mode it wraps back to 1. In
//   one-shot mode it stops at the rollover value and flags done.
//   Start, stop and pause control is provided. Mode, prescale and rollover are
//   captured when a reload start is accepted. A saturating counter tracks how
//   many continuous wraps have occurred.
//
// Ports
//   clk            system clock; all state updates on posedge
//   n_rst          synchronous active-low reset
//   clear          synchronous clear: counters/flags to 0, FSM to IDLE
//   start          reload start (IDLE/DONE) or resume (PAUSE)
//   stop           RUN -> PAUSE, count held
//   count_enable   tick qualifier, sampled each posedge
//   mode           0 = continuous, 1 = one-shot (captured at start)
//   prescale       tick every prescale+1 enabled cycles (captured at start)
//   rollover_val   terminal count (captured at start)
//   count_out      current count
//   rollover_flag  high while count_out equals the captured rollover value
//   wrap_pulse     one-cycle pulse on each continuous wrap rv -> 1
//   wrap_count     wraps since reload/clear, saturating at all-ones
//   busy           high in RUN
//   done           high in DONE
//   cfg_err        one-cycle pulse when a start is rejected (rollover_val == 0)
// -----------------------------------------------------------------------------
module prog_timer #(
  parameter int NUM_BITS  = 4,
  parameter int PS_BITS   = 4,
  parameter int WRAP_BITS = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 count_enable,
  input  logic                 mode,
  input  logic [PS_BITS-1:0]   prescale,
  input  logic [NUM_BITS-1:0]  rollover_val,
  output logic [NUM_BITS-1:0]  count_out,
  output logic                 rollover_flag,
  output logic                 wrap_pulse,
  output logic [WRAP_BITS-1:0] wrap_count,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [NUM_BITS-1:0]  COUNT_ONE = 1;
  localparam logic [PS_BITS-1:0]   PS_ONE    = 1;
  localparam logic [WRAP_BITS-1:0] WRAP_ONE  = 1;
  localparam logic [WRAP_BITS-1:0] WRAP_MAX  = '1;

  state_t               state_reg;
  logic [NUM_BITS-1:0]  count_reg;
  logic [PS_BITS-1:0]   ps_ctr_reg;
  logic [WRAP_BITS-1:0] wrap_count_reg;
  logic                 rollover_flag_reg;
  logic                 wrap_pulse_reg;
  logic                 cfg_err_reg;
  logic                 done_reg;
  logic                 busy_reg;

  // Shadow copies of the configuration, frozen for the whole run
  logic                 mode_reg;
  logic [PS_BITS-1:0]   prescale_reg;
  logic [NUM_BITS-1:0]  rv_reg;

  logic [NUM_BITS-1:0]  count_next;
  logic                 tick;

  // count_reg < rv_reg whenever this is used, so it never overflows
  assign count_next = count_reg + COUNT_ONE;
  assign tick       = count_enable && (ps_ctr_reg == prescale_reg);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg         <= IDLE;
      count_reg         <= '0;
      ps_ctr_reg        <= '0;
      wrap_count_reg    <= '0;
      rollover_flag_reg <= 1'b0;
      wrap_pulse_reg    <= 1'b0;
      cfg_err_reg       <= 1'b0;
      done_reg          <= 1'b0;
      busy_reg          <= 1'b0;
      mode_reg          <= 1'b0;
      prescale_reg      <= '0;
      rv_reg            <= '0;
    end else begin
      // Pulses default low and are raised only on the cycle they report
      wrap_pulse_reg <= 1'b0;
      cfg_err_reg    <= 1'b0;

      if (clear) begin
        state_reg         <= IDLE;
        count_reg         <= '0;
        ps_ctr_reg        <= '0;
        wrap_count_reg    <= '0;
        rollover_flag_reg <= 1'b0;
        done_reg          <= 1'b0;
        busy_reg          <= 1'b0;
      end else begin
        case (state_reg)
          IDLE, DONE: begin
            // stop outranks start, so a simultaneous stop suppresses the reload
            if (start && !stop) begin
              if (rollover_val != '0) begin
                mode_reg          <= mode;
                prescale_reg      <= prescale;
                rv_reg            <= rollover_val;
                count_reg         <= '0;
                ps_ctr_reg        <= '0;
                wrap_count_reg    <= '0;
                rollover_flag_reg <= 1'b0;
                done_reg          <= 1'b0;
                busy_reg          <= 1'b1;
                state_reg         <= RUN;
              end else begin
                cfg_err_reg <= 1'b1;
              end
            end
          end

          RUN: begin
            if (stop) begin
              busy_reg  <= 1'b0;
              state_reg <= PAUSE;
            end else if (tick) begin
              ps_ctr_reg <= '0;
              if (count_reg == rv_reg) begin
                // Only reachable in continuous mode: one-shot leaves RUN at rv
                count_reg      <= COUNT_ONE;
                wrap_pulse_reg <= 1'b1;
                if (wrap_count_reg != WRAP_MAX) begin
                  wrap_count_reg <= wrap_count_reg + WRAP_ONE;
                end
                // With rv == 1 the count never leaves rv, so the flag stays up
                rollover_flag_reg <= (rv_reg == COUNT_ONE);
              end else begin
                count_reg         <= count_next;
                rollover_flag_reg <= (count_next == rv_reg);
                if (mode_reg && (count_next == rv_reg)) begin
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
                end
              end
            end else if (count_enable) begin
              ps_ctr_reg <= ps_ctr_reg + PS_ONE;
            end
          end

          PAUSE: begin
            // Resume without recapture or reload
            if (start && !stop) begin
              busy_reg  <= 1'b1;
              state_reg <= RUN;
            end
          end

          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count_out     = count_reg;
  assign rollover_flag = rollover_flag_reg;
  assign wrap_pulse    = wrap_pulse_reg;
  assign wrap_count    = wrap_count_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign cfg_err       = cfg_err_reg;

endmodule

// File: tb/tb_prog_timer.sv
// -----------------------------------------------------------------------------
// tb_prog_timer
//   Directed bench for prog_timer. A default instance (WRAP_BITS = 8) and a
//   narrow instance (WRAP_BITS = 2) share every input. Each check is an
//   immediate assertion against hand-computed values.
// -----------------------------------------------------------------------------
module tb_prog_timer;

  logic       tb_clk;
  logic       n_rst;
  logic       clear;
  logic       start;
  logic       stop;
  logic       count_enable;
  logic       mode;
  logic [3:0] prescale;
  logic [3:0] rollover_val;

  logic [3:0] count_out;
  logic       rollover_flag;
  logic       wrap_pulse;
  logic [7:0] wrap_count;
  logic       busy;
  logic       done;
  logic       cfg_err;

  logic [3:0] count_out2;
  logic       rollover_flag2;
  logic       wrap_pulse2;
  logic [1:0] wrap_count2;
  logic       busy2;
  logic       done2;
  logic       cfg_err2;

  int checks   = 0;
  int failures = 0;

  prog_timer #(.NUM_BITS(4), .PS_BITS(4), .WRAP_BITS(8)) dut (
    .clk           (tb_clk),
    .n_rst         (n_rst),
    .clear         (clear),
    .start         (start),
    .stop          (stop),
    .count_enable  (count_enable),
    .mode          (mode),
    .prescale      (prescale),
    .rollover_val  (rollover_val),
    .count_out     (count_out),
    .rollover_flag (rollover_flag),
    .wrap_pulse    (wrap_pulse),
    .wrap_count    (wrap_count),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err)
  );

  prog_timer #(.NUM_BITS(4), .PS_BITS(4), .WRAP_BITS(2)) dut2 (
    .clk           (tb_clk),
    .n_rst         (n_rst),
    .clear         (clear),
    .start         (start),
    .stop          (stop),
    .count_enable  (count_enable),
    .mode          (mode),
    .prescale      (prescale),
    .rollover_val  (rollover_val),
    .count_out     (count_out2),
    .rollover_flag (rollover_flag2),
    .wrap_pulse    (wrap_pulse2),
    .wrap_count    (wrap_count2),
    .busy          (busy2),
    .done          (done2),
    .cfg_err       (cfg_err2)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: wait for the edge, then settle 1 time unit before sampling
  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_count"}, count_out, 0);
    chk({tag, "_flag"},  rollover_flag, 0);
    chk({tag, "_wp"},    wrap_pulse, 0);
    chk({tag, "_wc"},    wrap_count, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_cfg"},   cfg_err, 0);
  endtask

  // Expected sequence for continuous rv=3, prescale=0
  logic [3:0] exp_cnt  [5] = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2};
  logic       exp_flag [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       exp_wp   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [7:0] exp_wc   [5] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1};

  initial begin
    n_rst = 1'b0; clear = 1'b0; start = 1'b0; stop = 1'b0;
    count_enable = 1'b0; mode = 1'b0; prescale = 4'd0; rollover_val = 4'd0;

    // ---- Reset: two edges low, release between edges
    steps(2);
    chk_idle_zero("rst");
    @(negedge tb_clk);
    n_rst = 1'b1;
    step();
    chk_idle_zero("rst_rel");
    $display("txn reset: count=%0d busy=%0b", count_out, busy);

    // ---- Continuous rv=3 prescale=0
    mode = 1'b0; prescale = 4'd0; rollover_val = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    chk("cont_start_busy", busy, 1);
    chk("cont_start_count", count_out, 0);
    count_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("cont_cnt%0d", i), count_out, exp_cnt[i]);
      chk($sformatf("cont_flag%0d", i), rollover_flag, exp_flag[i]);
      chk($sformatf("cont_wp%0d", i), wrap_pulse, exp_wp[i]);
      chk($sformatf("cont_wc%0d", i), wrap_count, exp_wc[i]);
      $display("txn cont tick%0d: count=%0d flag=%0b wp=%0b wc=%0d",
               i, count_out, rollover_flag, wrap_pulse, wrap_count);
    end
    count_enable = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_idle_zero("clear1");

    // ---- One-shot rv=5
    mode = 1'b1; rollover_val = 4'd5; start = 1'b1;
    step();
    start = 1'b0;
    count_enable = 1'b1;
    steps(4);
    chk("os_cnt4", count_out, 4);
    chk("os_busy4", busy, 1);
    step();
    chk("os_cnt5", count_out, 5);
    chk("os_flag", rollover_flag, 1);
    chk("os_done", done, 1);
    chk("os_busy", busy, 0);
    steps(3);
    chk("os_hold_cnt", count_out, 5);
    chk("os_hold_done", done, 1);
    chk("os_hold_flag", rollover_flag, 1);
    $display("txn oneshot: count=%0d done=%0b busy=%0b", count_out, done, busy);

    // ---- Prescale=2 rv=15, reload straight from DONE
    count_enable = 1'b0;
    mode = 1'b0; prescale = 4'd2; rollover_val = 4'd15; start = 1'b1;
    step();
    start = 1'b0;
    chk("ps_reload_cnt", count_out, 0);
    chk("ps_reload_done", done, 0);
    chk("ps_reload_flag", rollover_flag, 0);
    count_enable = 1'b1;
    steps(9);
    chk("ps_cnt9", count_out, 3);
    // Config inputs changed mid-run must be ignored
    prescale = 4'd0; rollover_val = 4'd2; mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      count_enable = (i % 2 == 1);
      step();
    end
    chk("ps_toggle_cnt", count_out, 4);
    chk("ps_toggle_busy", busy, 1);
    $display("txn prescale: count=%0d", count_out);

    // ---- Stop / resume, clear+start, rejected start
    count_enable = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    mode = 1'b0; prescale = 4'd0; rollover_val = 4'd9; start = 1'b1;
    step();
    start = 1'b0;
    count_enable = 1'b1;
    steps(2);
    chk("ss_cnt2", count_out, 2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("ss_pause_busy", busy, 0);
    steps(4);
    chk("ss_hold_cnt", count_out, 2);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ss_resume_busy", busy, 1);
    step();
    chk("ss_resume_cnt", count_out, 3);
    clear = 1'b1; start = 1'b1;
    step();
    clear = 1'b0; start = 1'b0;
    chk("cs_cnt", count_out, 0);
    chk("cs_busy", busy, 0);
    rollover_val = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("cfg_err_pulse", cfg_err, 1);
    chk("cfg_err_busy", busy, 0);
    step();
    chk("cfg_err_clr", cfg_err, 0);
    $display("txn stopstart: cfg_err_seen busy=%0b", busy);

    // ---- Reset mid-run
    rollover_val = 4'd9; start = 1'b1;
    step();
    start = 1'b0;
    steps(6);
    chk("mr_cnt6", count_out, 6);
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    chk_idle_zero("mr_rst");

    // ---- rv=1 continuous on the 2-bit wrap counter: saturates at 3
    rollover_val = 4'd1; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("w2_cnt1", count_out2, 1);
    chk("w2_flag1", rollover_flag2, 1);
    chk("w2_wp1", wrap_pulse2, 0);
    steps(2);
    chk("w2_wc2", wrap_count2, 2);
    chk("w2_wp", wrap_pulse2, 1);
    chk("w2_flag", rollover_flag2, 1);
    steps(3);
    chk("w2_wc_sat", wrap_count2, 3);
    chk("w2_cnt", count_out2, 1);
    chk("w8_wc5", wrap_count, 5);
    $display("txn wrap2: wc2=%0d wc8=%0d", wrap_count2, wrap_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
